// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - clocked asynchronous-SRAM pin emulator backed by block RAM
// Writes commit when the strobe releases, and reads return data after one cycle.
module sram_responder #(
   parameter int ADDR_BITS  = 10,
   parameter int DATA_BITS  = 8,
   parameter int COUNT_BITS = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ce_n,
   input  logic                  we_n,
   input  logic                  oe_n,
   input  logic [ADDR_BITS-1:0]  addr,
   input  logic [DATA_BITS-1:0]  data_in,
   output logic [DATA_BITS-1:0]  data_out,
   output logic                  data_oe,
   output logic [COUNT_BITS-1:0] write_count,
   output logic [COUNT_BITS-1:0] read_count,
   output logic                  err_conflict
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t                 state, state_next;
   logic [DATA_BITS-1:0]   mem [0:DEPTH-1];
   logic [ADDR_BITS-1:0]   waddr;
   logic [DATA_BITS-1:0]   wdata;
   logic [ADDR_BITS-1:0]   last_addr;

   logic wr, rd, conflict;
   logic capture, commit, read_load, read_inc;

   // A simultaneous we_n/oe_n is a write by construction, because rd requires we_n high.
   assign wr       = !ce_n && !we_n;
   assign rd       = !ce_n && !oe_n && we_n;
   assign conflict = !ce_n && !we_n && !oe_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      commit     = 1'b0;
      read_load  = 1'b0;
      read_inc   = 1'b0;
      case (state)
         IDLE: begin
            if (wr) begin
               state_next = WRITE;
               capture    = 1'b1;
            end else if (rd) begin
               state_next = READ;
               read_load  = 1'b1;
               read_inc   = 1'b1;
            end
         end
         WRITE: begin
            if (wr) begin
               capture = 1'b1;
            end else begin
               commit = 1'b1;
               if (rd) begin
                  state_next = READ;
                  read_load  = 1'b1;
                  read_inc   = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         READ: begin
            if (rd) begin
               read_load = 1'b1;
               read_inc  = (addr != last_addr);
            end else if (wr) begin
               state_next = WRITE;
               capture    = 1'b1;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The memory has no reset, so its contents survive reset_n.
   always_ff @(posedge clk) begin
      if (commit) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_out     <= '0;
         data_oe      <= 1'b0;
         write_count  <= '0;
         read_count   <= '0;
         err_conflict <= 1'b0;
         waddr        <= '0;
         wdata        <= '0;
         last_addr    <= '0;
      end else begin
         last_addr <= addr;
         data_oe   <= (state_next == READ);
         if (capture) begin
            waddr <= addr;
            wdata <= data_in;
         end
         if (commit)   write_count <= write_count + COUNT_BITS'(1);
         if (read_inc) read_count  <= read_count + COUNT_BITS'(1);
         if (conflict) err_conflict <= 1'b1;
         // The write committing on this same edge is not yet visible in mem.
         if (read_load) begin
            if (commit && addr == waddr) data_out <= wdata;
            else                         data_out <= mem[addr];
         end
      end
   end

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed self-checking bench for sram_responder
module tb_sram_responder;

   logic        clk;
   logic        reset_n;
   logic        ce_n, we_n, oe_n;
   logic [9:0]  addr;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        data_oe;
   logic [15:0] write_count;
   logic [15:0] read_count;
   logic        err_conflict;

   int n_vec = 0;
   int n_err = 0;

   sram_responder dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ce_n         (ce_n),
      .we_n         (we_n),
      .oe_n         (oe_n),
      .addr         (addr),
      .data_in      (data_in),
      .data_out     (data_out),
      .data_oe      (data_oe),
      .write_count  (write_count),
      .read_count   (read_count),
      .err_conflict (err_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_pins();
      ce_n = 1'b1;
      we_n = 1'b1;
      oe_n = 1'b1;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      logic [7:0] exp_word;

      reset_n = 1'b0;
      idle_pins();
      addr    = '0;
      data_in = '0;
      tick();
      tick();
      check("rst_oe",   32'(data_oe), 32'h0);
      check("rst_dout", 32'(data_out), 32'h0);
      check("rst_wcnt", 32'(write_count), 32'h0);
      check("rst_rcnt", 32'(read_count), 32'h0);
      check("rst_err",  32'(err_conflict), 32'h0);
      reset_n = 1'b1;
      tick();

      // Write 0xA5 to 0x003, strobe held for two cycles, then read it back.
      ce_n = 1'b0; we_n = 1'b0; addr = 10'h003; data_in = 8'hA5;
      tick();
      tick();
      check("wr_oe_low", 32'(data_oe), 32'h0);
      check("wr_no_commit_yet", 32'(write_count), 32'h0);
      idle_pins();
      tick();
      check("wr_wcnt", 32'(write_count), 32'h1);
      ce_n = 1'b0; oe_n = 1'b0; addr = 10'h003;
      tick();
      check("rd_oe",   32'(data_oe), 32'h1);
      check("rd_dout", 32'(data_out), 32'hA5);
      check("rd_rcnt", 32'(read_count), 32'h1);
      idle_pins();
      tick();
      check("rd_exit_oe",   32'(data_oe), 32'h0);
      check("rd_exit_hold", 32'(data_out), 32'hA5);

      // Full sweep from fresh counters; memory keeps its contents across reset.
      pulse_reset();
      for (int i = 0; i < 1024; i++) begin
         ce_n = 1'b0; we_n = 1'b0; addr = i[9:0]; data_in = i[7:0] ^ 8'h5A;
         tick();
         we_n = 1'b1;
         tick();
      end
      idle_pins();
      tick();
      check("sweep_wcnt", 32'(write_count), 32'd1024);
      ce_n = 1'b0; oe_n = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         addr = i[9:0];
         exp_word = i[7:0] ^ 8'h5A;
         tick();
         check($sformatf("sweep_rd_%0d", i), 32'(data_out), 32'(exp_word));
      end
      idle_pins();
      tick();
      check("sweep_rcnt", 32'(read_count), 32'd1024);
      check("sweep_oe_off", 32'(data_oe), 32'h0);

      // A held address counts once; a new address under the same strobe counts again.
      ce_n = 1'b0; oe_n = 1'b0; addr = 10'h005;
      tick();
      tick();
      tick();
      check("hold_rcnt", 32'(read_count), 32'd1025);
      addr = 10'h006;
      tick();
      check("step_rcnt", 32'(read_count), 32'd1026);
      check("step_dout", 32'(data_out), 32'(8'h06 ^ 8'h5A));
      idle_pins();
      tick();

      // Mid-strobe address/data change: only the last sample is committed.
      ce_n = 1'b0; we_n = 1'b0; addr = 10'h010; data_in = 8'h11;
      tick();
      addr = 10'h020; data_in = 8'h22;
      tick();
      idle_pins();
      tick();
      check("mid_wcnt", 32'(write_count), 32'd1025);
      ce_n = 1'b0; oe_n = 1'b0; addr = 10'h010;
      tick();
      check("mid_old_addr", 32'(data_out), 32'h4A);
      addr = 10'h020;
      tick();
      check("mid_new_addr", 32'(data_out), 32'h22);
      idle_pins();
      tick();

      // Direct forward: write release and read entry share one edge.
      ce_n = 1'b0; we_n = 1'b0; addr = 10'h040; data_in = 8'h7E;
      tick();
      we_n = 1'b1; oe_n = 1'b0;
      tick();
      check("fwd_dout", 32'(data_out), 32'h7E);
      check("fwd_oe",   32'(data_oe), 32'h1);
      check("fwd_wcnt", 32'(write_count), 32'd1026);
      idle_pins();
      tick();
      ce_n = 1'b0; oe_n = 1'b0;
      tick();
      check("fwd_committed", 32'(data_out), 32'h7E);
      idle_pins();
      tick();

      // Conflict: a read in progress is overridden by we_n falling.
      ce_n = 1'b0; oe_n = 1'b0; addr = 10'h3FF;
      tick();
      check("cf_pre_oe",   32'(data_oe), 32'h1);
      check("cf_pre_dout", 32'(data_out), 32'hA5);
      we_n = 1'b0; data_in = 8'hA5;
      tick();
      check("cf_oe",  32'(data_oe), 32'h0);
      check("cf_err", 32'(err_conflict), 32'h1);
      idle_pins();
      for (int i = 0; i < 10; i++) tick();
      check("cf_sticky",  32'(err_conflict), 32'h1);
      check("cf_is_write", 32'(write_count), 32'd1027);
      pulse_reset();
      check("cf_cleared", 32'(err_conflict), 32'h0);

      // Reset mid-write: the strobed data must never reach memory.
      ce_n = 1'b0; we_n = 1'b0; addr = 10'h055; data_in = 8'h99;
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      check("rstw_oe_async", 32'(data_oe), 32'h0);
      tick();
      check("rstw_oe_held", 32'(data_oe), 32'h0);
      check("rstw_wcnt_in", 32'(write_count), 32'h0);
      idle_pins();
      tick();
      reset_n = 1'b1;
      tick();
      ce_n = 1'b0; oe_n = 1'b0; addr = 10'h055;
      tick();
      check("rstw_dout", 32'(data_out), 32'h0F);
      check("rstw_wcnt", 32'(write_count), 32'h0);
      check("rstw_rcnt", 32'(read_count), 32'h1);
      idle_pins();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable, clocked emulation of an asynchronous SRAM device at the pin level. It is the responder for the ce_n/we_n/oe_n/addr/data pin interface that sram_tester drives.
- Lets the SRAM tester and future SRAM controllers run on hardware against on-chip block RAM, with no external part fitted.
- Samples pins on clk, commits writes on strobe release, returns read data with fixed one-cycle latency, and counts and flags accesses.
- The top level builds the inout data bus from data_in/data_out/data_oe.

Parameters:
- ADDR_BITS, 10, address width; memory depth is 2**ADDR_BITS words.
- DATA_BITS, 8, data word width.
- COUNT_BITS, 16, width of the access counters.

Ports:
- clk  input  1  system clock; all pin sampling on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ce_n  input  1  chip enable, active low.
- we_n  input  1  write enable, active low.
- oe_n  input  1  output enable, active low.
- addr  input  ADDR_BITS  address pins.
- data_in  input  DATA_BITS  data bus value as seen by the device.
- data_out  output  DATA_BITS  read data to drive onto the bus.
- data_oe  output  1  bus drive enable; the top level tristates data when 0.
- write_count  output  COUNT_BITS  number of committed writes.
- read_count  output  COUNT_BITS  number of read accesses.
- err_conflict  output  1  sticky flag: we_n and oe_n were both low while selected.

Behaviour:
- Strobe definitions, sampled each rising edge:
  - wr = !ce_n && !we_n
  - rd = !ce_n && !oe_n && we_n
- Reset, asynchronous on reset_n low:
  - state = IDLE; data_out = 0; data_oe = 0; counters = 0; err_conflict = 0.
  - Memory contents are not cleared.
  - A write in progress is discarded and never committed.
- States: IDLE, WRITE, READ.
- IDLE:
  - wr -> WRITE; capture waddr = addr, wdata = data_in.
  - else rd -> READ (read entry rules below).
  - else stay in IDLE.
- WRITE:
  - While wr holds, recapture waddr and wdata every cycle. The last sampled values win, so address or data changes mid-strobe are tolerated.
  - On the first edge with wr low:
    - commit mem[waddr] = wdata;
    - write_count += 1;
    - next state is READ if rd, otherwise IDLE.
- READ entry (from IDLE or WRITE):
  - data_out = mem[addr]; data_oe = 1; read_count += 1.
  - Both are valid in the cycle after the first edge at which rd is sampled high (latency 1).
- READ, while rd holds:
  - data_out = mem[addr] every cycle.
  - read_count += 1 only when addr differs from the previous cycle's sampled addr.
- READ exit, when rd drops:
  - data_oe = 0 at that edge.
  - data_out holds its last value.
  - Next state is WRITE if wr, otherwise IDLE.
- Write-to-read forwarding: on a WRITE -> READ transition, if addr == waddr, data_out = wdata, never stale memory.
- Conflict: we_n=0 and oe_n=0 with ce_n=0 at the same edge:
  - the cycle is treated as a write (wr);
  - data_oe is forced 0 at that edge;
  - err_conflict is set and stays set until reset.
- ce_n high: no access; any WRITE in progress commits as above.
- Counters wrap modulo 2**COUNT_BITS and never saturate.
- data_oe is never 1 in IDLE or WRITE.

Test Plan:
- Write then read back: write 0xA5 to 0x003 (we_n low for 2 cycles, then high) -> write_count=1. Then oe_n low at 0x003 -> data_oe=1 and data_out=0xA5 one cycle later; read_count=1.
- Full sweep: write the pattern addr[7:0]^0x5A to all 1024 addresses, then read them all back -> every word matches; write_count=1024; read_count=1024 with addr stepping each cycle under continuous oe_n.
- Mid-strobe change: hold we_n low with addr 0x010/data 0x11, then addr 0x020/data 0x22 before release -> only mem[0x020]=0x22 is committed; mem[0x010] is unchanged; write_count=1.
- Direct forward: release we_n at 0x040/0x7E and lower oe_n on the same edge at 0x040 -> next cycle data_out=0x7E, data_oe=1.
- Conflict: ce_n=0, we_n=0, oe_n=0 for 1 cycle -> data_oe=0, err_conflict=1 and still 1 after 10 idle cycles. A later reset_n pulse clears it.
- Reset mid-write: assert reset_n low while we_n is low at 0x055/0x99, release reset, then read 0x055 -> previous contents are returned (not 0x99); write_count=0; data_oe=0 throughout reset.
